// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the ALU execute stages.
//   ALU_OP_ADD / ALU_OP_SUB : encoding of the 1-bit operation select.
//   ALU_DEFAULT_WIDTH       : default datapath width in bits.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic ALU_OP_ADD        = 1'b0;
    localparam logic ALU_OP_SUB        = 1'b1;
    localparam int   ALU_DEFAULT_WIDTH = 32;

endpackage : alu_pkg

// File: rtl/alu_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_addsub_pipe_if
//   Operand and result channels of the add/subtract pipeline.
//   Ports (all carried as interface signals):
//     i_valid, o_ready, i_a, i_b, i_op         : operand channel (upstream)
//     o_valid, i_ready, o_result, o_cout,
//     o_zero, o_neg, o_ovf                     : result channel (downstream)
//   Modports: slave  = pipeline side, master = producer/consumer side.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. A sender holding valid high keeps its payload stable until the
//   transfer; ready may depend on registered state and the other channel's
//   ready, but never on the same channel's valid.
// -----------------------------------------------------------------------------
interface alu_addsub_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
);

    // operand channel
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_op;

    // result channel
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_op, i_ready,
        output o_ready, o_valid, o_result, o_cout, o_zero, o_neg, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_op, i_ready,
        input  o_ready, o_valid, o_result, o_cout, o_zero, o_neg, o_ovf
    );

endinterface : alu_addsub_pipe_if

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Combinational WIDTH-bit adder with carry in/out.
//   i_a, i_b  : addends
//   i_cin     : carry in
//   o_result  : i_a + i_b + i_cin modulo 2^WIDTH
//   o_cout    : carry out of the MSB
// -----------------------------------------------------------------------------
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);

    assign {o_cout, o_result} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule : adder

// File: rtl/alu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// alu_addsub_pipe
//   Two-stage pipelined add/subtract execute stage.
//   S1 registers the adder inputs (B inverted and carry-in set for subtract),
//   a single adder sits between S1 and S2, and S2 registers the result plus
//   carry, zero, negative and signed-overflow flags. One op per cycle when
//   the consumer does not stall.
//
//   Ports:
//     i_clk    : clock, rising edge
//     i_rst_n  : synchronous active-low reset
//     bus      : alu_addsub_pipe_if.slave (operand and result channels)
//
//   Build option:
//     ALU_ADDSUB_SAT_EN : when defined, an overflowing result saturates to the
//                         most positive / most negative value; o_ovf still
//                         reports 1 and o_cout stays the raw carry.
// -----------------------------------------------------------------------------
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_addsub_pipe_if.slave   bus
);

    localparam int MSB = WIDTH - 1;

    // ---------------- stage registers ----------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_cin_q,   s1_cin_d;

    logic             s2_valid_q,  s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_cout_q,   s2_cout_d;
    logic             s2_zero_q,   s2_zero_d;
    logic             s2_neg_q,    s2_neg_d;
    logic             s2_ovf_q,    s2_ovf_d;

    // ---------------- handshake ----------------
    logic s2_adv;
    logic accept;

    // S2 can take S1's op if it is empty or being drained this edge.
    assign s2_adv = s1_valid_q && (!s2_valid_q || bus.i_ready);
    // Built only from registered state and i_ready, never from i_valid.
    assign bus.o_ready = !s1_valid_q || s2_adv;
    assign accept      = bus.i_valid && bus.o_ready;

    // ---------------- adder between S1 and S2 ----------------
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] final_result;

    adder #(.WIDTH(WIDTH)) u_adder (
        .i_a      (s1_a_q),
        .i_b      (s1_b_q),
        .i_cin    (s1_cin_q),
        .o_result (sum),
        .o_cout   (cout)
    );

    // Same-sign inputs (after the B inversion) producing a different-sign sum.
    assign ovf = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);

`ifdef ALU_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the sign of A gives the direction of the true result.
    always_comb begin
        final_result = sum;
        if (ovf) begin
            final_result = s1_a_q[MSB] ? MAX_NEG : MAX_POS;
        end
    end
`else
    assign final_result = sum;
`endif

    // ---------------- next state ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.i_a;
            s1_b_d     = (bus.i_op == ALU_OP_SUB) ? ~bus.i_b : bus.i_b;
            s1_cin_d   = (bus.i_op == ALU_OP_SUB);
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_cout_d   = s2_cout_q;
        s2_zero_d   = s2_zero_q;
        s2_neg_d    = s2_neg_q;
        s2_ovf_d    = s2_ovf_q;

        if (s2_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = final_result;
            s2_cout_d   = cout;
            s2_zero_d   = (final_result == '0);
            s2_neg_d    = final_result[MSB];
            s2_ovf_d    = ovf;
        end else if (bus.i_ready) begin
            s2_valid_d  = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_cout_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_cout_q   <= s2_cout_d;
            s2_zero_q   <= s2_zero_d;
            s2_neg_q    <= s2_neg_d;
            s2_ovf_q    <= s2_ovf_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_valid  = s2_valid_q;
    assign bus.o_result = s2_result_q;
    assign bus.o_cout   = s2_cout_q;
    assign bus.o_zero   = s2_zero_q;
    assign bus.o_neg    = s2_neg_q;
    assign bus.o_ovf    = s2_ovf_q;

endmodule : alu_addsub_pipe

// File: tb/tb_alu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_addsub_pipe
//   Bench for alu_addsub_pipe at WIDTH=32. Packed observation/expectation
//   layout: {result, cout, zero, neg, ovf}.
// -----------------------------------------------------------------------------
module tb_alu_addsub_pipe;

    localparam int W  = 32;
    localparam int PW = W + 4;

    logic i_clk;
    logic i_rst_n;

    alu_addsub_pipe_if #(.WIDTH(W)) bus ();

    alu_addsub_pipe #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: signed/unsigned arithmetic in 64 bits.
    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic op);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic [W-1:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op) begin
            sr = sa - sb;
            c  = (a >= b);
        end else begin
            sr = sa + sb;
            c  = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        end
        v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        r = sr[W-1:0];
`ifdef ALU_ADDSUB_SAT_EN
        if (v) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {r, c, (r == '0), r[W-1], v};
    endfunction

    // One clock of stimulus. Inputs are applied just after a rising edge,
    // everything is observed on the falling edge. Pushes the model result
    // when the operand handshake fires; reports whether the result handshake
    // fires and what the outputs were.
    task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic op, input logic rdy,
                               output logic accepted, output logic fired,
                               output logic [PW-1:0] obs);
        bus.i_valid = v;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_op    = op;
        bus.i_ready = rdy;
        @(negedge i_clk);
        accepted = v && bus.o_ready;
        fired    = bus.o_valid && bus.i_ready;
        obs      = {bus.o_result, bus.o_cout, bus.o_zero, bus.o_neg, bus.o_ovf};
        if (accepted) exp_q.push_back(model(a, b, op));
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_op    = 1'b0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid);
        else n_pass++;
        n_checks++;
        if (bus.o_ready !== 1'b1) $display("FAIL reset_o_ready: got %b expected 1", bus.o_ready);
        else n_pass++;
        n_checks++;
        if ({bus.o_result, bus.o_cout, bus.o_zero, bus.o_neg, bus.o_ovf} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.o_result, bus.o_cout, bus.o_zero, bus.o_neg, bus.o_ovf});
        else n_pass++;
        @(posedge i_clk);
        #1;
    endtask

    // One op through an otherwise idle pipe: checks latency, the model and a
    // hand-derived constant.
    task automatic directed_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic op, input logic [PW-1:0] want);
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        drive_cycle(1'b1, a, b, op, 1'b1, acc, fired, obs);
        n_checks++;
        if (acc !== 1'b1) $display("FAIL %s_accept: got %b expected 1", name, acc);
        else n_pass++;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, fired, obs);
        n_checks++;
        if (fired !== 1'b0) $display("FAIL %s_early_valid: got %b expected 0", name, fired);
        else n_pass++;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, fired, obs);
        n_checks++;
        if (fired !== 1'b1) begin
            $display("FAIL %s_latency: o_valid got %b expected 1", name, fired);
        end else begin
            n_pass++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (obs !== exp) $display("FAIL %s_model: got %h expected %h", name, obs, exp);
            else n_pass++;
            n_checks++;
            if (obs !== want) $display("FAIL %s_const: got %h expected %h", name, obs, want);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_directed();
        // {result, cout, zero, neg, ovf}
        directed_op("add_5_7",   32'd5,      32'd7, 1'b0, {32'd12, 4'b0000});
        directed_op("sub_3_5",   32'd3,      32'd5, 1'b1, {32'hFFFF_FFFE, 4'b0010});
        directed_op("sub_equal", 32'h1234,   32'h1234, 1'b1, {32'd0, 4'b1100});
`ifdef ALU_ADDSUB_SAT_EN
        directed_op("add_ovf",   32'h7FFF_FFFF, 32'd1, 1'b0, {32'h7FFF_FFFF, 4'b0001});
        directed_op("sub_ovf",   32'h8000_0000, 32'd1, 1'b1, {32'h8000_0000, 4'b1011});
`else
        directed_op("add_ovf",   32'h7FFF_FFFF, 32'd1, 1'b0, {32'h8000_0000, 4'b0011});
        directed_op("sub_ovf",   32'h8000_0000, 32'd1, 1'b1, {32'h7FFF_FFFF, 4'b1001});
`endif
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a_t[4] = '{32'd10, 32'd20, 32'hFFFF_FFFF, 32'd100};
        logic [W-1:0] b_t[4] = '{32'd1,  32'd25, 32'd1,         32'd100};
        logic         o_t[4] = '{1'b0,   1'b1,   1'b0,          1'b1};
        int idx = 0;
        int outs = 0;
        logic acc, fired;
        logic [PW-1:0] obs, exp, snap;
        snap = '0;
        for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
            logic v = (idx < 4);
            logic rdy = (cyc >= 5);
            drive_cycle(v, v ? a_t[idx] : '0, v ? b_t[idx] : '0, v ? o_t[idx] : 1'b0, rdy,
                        acc, fired, obs);
            if (acc) idx++;
            if (cyc == 1) begin
                n_checks++;
                if (idx !== 2) $display("FAIL bp_two_accepts: got %0d expected 2", idx);
                else n_pass++;
            end
            if (cyc >= 2 && cyc <= 4) begin
                n_checks++;
                if (acc !== 1'b0) $display("FAIL bp_o_ready_low: cycle %0d accepted %b expected 0", cyc, acc);
                else n_pass++;
                if (cyc == 2) snap = obs;
                n_checks++;
                if (obs !== snap) $display("FAIL bp_hold: cycle %0d got %h expected %h", cyc, obs, snap);
                else n_pass++;
            end
            if (fired) begin
                outs++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_unexpected_output: got %h expected none", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) $display("FAIL bp_result: got %h expected %h", obs, exp);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (outs !== 4 || exp_q.size() != 0)
            $display("FAIL bp_count: got %0d outputs, %0d pending, expected 4 and 0", outs, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic acc, fired;
        logic [PW-1:0] obs;
        int spurious = 0;
        drive_cycle(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, acc, fired, obs);
        drive_cycle(1'b1, 32'd3, 32'd4, 1'b1, 1'b1, acc, fired, obs);
        // Both ops are in flight now; reset for one edge.
        i_rst_n = 1'b0;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, acc, fired, obs);
        i_rst_n = 1'b1;
        exp_q.delete();
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) $display("FAIL rstmid_o_valid: got %b expected 0", bus.o_valid);
        else n_pass++;
        n_checks++;
        if (bus.o_ready !== 1'b1) $display("FAIL rstmid_o_ready: got %b expected 1", bus.o_ready);
        else n_pass++;
        n_checks++;
        if ({bus.o_result, bus.o_cout, bus.o_zero, bus.o_neg, bus.o_ovf} !== '0)
            $display("FAIL rstmid_outputs: got %h expected 0",
                     {bus.o_result, bus.o_cout, bus.o_zero, bus.o_neg, bus.o_ovf});
        else n_pass++;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, fired, obs);
            if (fired) spurious++;
        end
        n_checks++;
        if (spurious !== 0) $display("FAIL rstmid_ghost: got %0d outputs expected 0", spurious);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] corner[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                    32'hFFFF_FFFF, 32'h8000_0001};
        int sent = 0;
        int errs = 0;
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        for (int cyc = 0; cyc < 60000 && (sent < 10000 || exp_q.size() > 0); cyc++) begin
            logic v, rdy, op;
            logic [W-1:0] a, b;
            v   = (sent < 10000) && ($urandom_range(0, 3) != 0);
            rdy = (sent >= 10000) || ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            b   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            op  = 1'($urandom_range(0, 1));
            drive_cycle(v, a, b, op, rdy, acc, fired, obs);
            if (acc) sent++;
            if (fired) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    if (errs < 10) $display("FAIL rand_unexpected_output: got %h expected none", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errs++;
                        if (errs < 10) $display("FAIL rand_result: got %h expected %h", obs, exp);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
        n_checks++;
        if (sent !== 10000 || exp_q.size() != 0)
            $display("FAIL rand_drain: sent %0d pending %0d expected 10000 and 0", sent, exp_q.size());
        else n_pass++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_addsub_pipe
